// File: rtl/edge_noise_filter.sv
`default_nettype none
// ============================================================================
// Module      : edge_noise_filter
// Description : Removes isolated pixels from a binary edge map held in SRAM
//               with a 3x3 neighbour-count filter, and counts the survivors.
// Revision    : 1.0  initial release
// ============================================================================
module edge_noise_filter #(
    parameter int WIDTH         = 320,
    parameter int HEIGHT        = 240,
    parameter int SRC_BASE      = 2240,
    parameter int DST_BASE      = 153600,
    parameter int MIN_NEIGHBORS = 1
) (
    input  logic             clk_div_by_two,
    input  logic             reset_n,
    input  logic             enable_edge_filter,
    input  logic [31:0]      data_read,
    output wire logic        wren,
    output wire logic [17:0] address,
    output wire logic [31:0] data_write,
    output logic             edge_filter_done,
    output logic [16:0]      edge_pixel_count
);

    localparam int              c_XW     = (WIDTH  > 2) ? $clog2(WIDTH)  : 2;
    localparam int              c_YW     = (HEIGHT > 2) ? $clog2(HEIGHT) : 2;
    localparam logic [17:0]     c_SRC    = 18'(SRC_BASE);
    localparam logic [17:0]     c_DST    = 18'(DST_BASE);
    localparam logic [17:0]     c_W      = 18'(WIDTH);
    localparam logic [c_XW-1:0] c_X_LAST = c_XW'(WIDTH - 1);
    localparam logic [c_YW-1:0] c_Y_LAST = c_YW'(HEIGHT - 2);
    localparam logic [4:0]      c_MIN    = 5'(MIN_NEIGHBORS);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_RD_TOP = 3'd1;
    localparam logic [2:0] c_RD_MID = 3'd2;
    localparam logic [2:0] c_RD_BOT = 3'd3;
    localparam logic [2:0] c_CAP    = 3'd4;
    localparam logic [2:0] c_WRITE  = 3'd5;
    localparam logic [2:0] c_NEXT   = 3'd6;
    localparam logic [2:0] c_DONE   = 3'd7;

    logic [2:0]      state_q, state_d;
    logic [c_XW-1:0] x_q, x_d;
    logic [c_YW-1:0] y_q, y_d;
    logic [17:0]     row_q, row_d;
    logic [8:0]      win_q, win_d;
    logic            top_q, top_d;
    logic            mid_q, mid_d;
    logic [16:0]     count_q, count_d;
    logic            drive_q;

    logic [3:0]      w_nbr;
    logic [4:0]      w_diff;
    logic            w_keep;
    logic [17:0]     w_x18;
    logic [17:0]     w_addr;
    logic            w_unused;

    // Window layout: [8:6] left, [5:3] centre, [2:0] right; each {top, mid, bottom}.
    always_comb begin
        w_nbr = 4'd0;
        for (int i = 0; i < 9; i++) begin
            if (i != 4) begin
                w_nbr = w_nbr + 4'(win_q[i]);
            end
        end
    end

    // Sign bit of (count - MIN) clear means count >= MIN.
    assign w_diff = {1'b0, w_nbr} - c_MIN;
    assign w_keep = win_q[4] & ~w_diff[4];
    assign w_x18  = 18'(x_q);

    always_comb begin
        w_addr = 18'd0;
        case (state_q)
            c_RD_TOP: w_addr = c_SRC + row_q - c_W + w_x18;
            c_RD_MID: w_addr = c_SRC + row_q + w_x18;
            c_RD_BOT: w_addr = c_SRC + row_q + c_W + w_x18;
            c_WRITE:  w_addr = c_DST + row_q + w_x18 - 18'd1;
            default:  w_addr = 18'd0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        row_d   = row_q;
        win_d   = win_q;
        top_d   = top_q;
        mid_d   = mid_q;
        count_d = count_q;
        case (state_q)
            c_IDLE: begin
                if (enable_edge_filter) begin
                    state_d = c_RD_TOP;
                    x_d     = '0;
                    y_d     = c_YW'(1);
                    row_d   = c_W;
                    count_d = '0;
                end
            end
            c_RD_TOP: state_d = c_RD_MID;
            c_RD_MID: begin
                top_d   = data_read[0];
                state_d = c_RD_BOT;
            end
            c_RD_BOT: begin
                mid_d   = data_read[0];
                state_d = c_CAP;
            end
            c_CAP: begin
                win_d   = {win_q[5:0], top_q, mid_q, data_read[0]};
                state_d = (x_q >= c_XW'(2)) ? c_WRITE : c_NEXT;
            end
            c_WRITE: begin
                // The write on the bus this cycle lands even if enable drops now.
                if (w_keep && (count_q != '1)) begin
                    count_d = count_q + 17'd1;
                end
                state_d = c_NEXT;
            end
            c_NEXT: begin
                if (x_q == c_X_LAST) begin
                    x_d     = '0;
                    y_d     = y_q + c_YW'(1);
                    row_d   = row_q + c_W;
                    state_d = (y_q == c_Y_LAST) ? c_DONE : c_RD_TOP;
                end else begin
                    x_d     = x_q + c_XW'(1);
                    state_d = c_RD_TOP;
                end
            end
            c_DONE:  state_d = c_DONE;
            default: state_d = c_IDLE;
        endcase
        if (!enable_edge_filter) begin
            state_d = c_IDLE;
        end
    end

    always_ff @(posedge clk_div_by_two) begin
        if (!reset_n) begin
            state_q <= c_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            row_q   <= '0;
            win_q   <= '0;
            top_q   <= 1'b0;
            mid_q   <= 1'b0;
            count_q <= '0;
            drive_q <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            row_q   <= row_d;
            win_q   <= win_d;
            top_q   <= top_d;
            mid_q   <= mid_d;
            count_q <= count_d;
            drive_q <= enable_edge_filter;
        end
    end

    // Bus is shared: drive it only in cycles following an enabled edge.
    assign wren       = drive_q ? (state_q == c_WRITE) : 1'bz;
    assign address    = drive_q ? w_addr : 18'bz;
    assign data_write = drive_q ? {31'd0, (state_q == c_WRITE) & w_keep} : 32'bz;

    assign edge_filter_done = (state_q == c_DONE);
    assign edge_pixel_count = count_q;

    assign w_unused = ^data_read[31:1];

endmodule
`default_nettype wire

// File: tb/tb_edge_noise_filter.sv
`default_nettype none
// ============================================================================
// Module      : tb_edge_noise_filter
// Description : Self-checking bench for edge_noise_filter on a small image
//               whose destination region wraps around the 18-bit address space.
// Revision    : 1.0  initial release
// ============================================================================
module tb_edge_noise_filter;

    localparam int W     = 12;
    localparam int H     = 10;
    localparam int SRC   = 100;
    localparam int DST   = 262144 - 50;
    localparam int MIN   = 1;
    localparam int NPIX  = W * H;
    localparam int ROW   = 2 * 5 + (W - 2) * 6;
    localparam int PASS  = (H - 2) * ROW + 1;
    localparam int NINT  = (W - 2) * (H - 2);

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic [31:0] data_read = 32'd0;
    wire         wren;
    wire  [17:0] address;
    wire  [31:0] data_write;
    logic        done;
    logic [16:0] count;

    edge_noise_filter #(
        .WIDTH(W), .HEIGHT(H), .SRC_BASE(SRC), .DST_BASE(DST), .MIN_NEIGHBORS(MIN)
    ) dut (
        .clk_div_by_two    (clk),
        .reset_n           (reset_n),
        .enable_edge_filter(enable),
        .data_read         (data_read),
        .wren              (wren),
        .address           (address),
        .data_write        (data_write),
        .edge_filter_done  (done),
        .edge_pixel_count  (count)
    );

    always #5 clk = ~clk;

    bit          src_img [NPIX];
    int          wr_cnt  [NPIX];
    bit          wr_val  [NPIX];
    int          n_writes, ones_wr, bad_wr, last_y;
    int          checks = 0;
    int          errors = 0;
    int          exp_cnt = 0;
    logic [17:0] rd_addr = 18'd0;

    // SRAM model: one-cycle read latency, garbage in the unused upper bits.
    always @(posedge clk) begin
        logic [17:0] off;
        off = rd_addr - 18'(SRC);
        data_read <= {31'($urandom), (int'(off) < NPIX) ? src_img[off] : 1'b0};
    end

    always @(negedge clk) begin
        logic [17:0] off;
        int px, py;
        rd_addr = address;
        if (wren === 1'b1) begin
            n_writes++;
            off = address - 18'(DST);
            if (int'(off) >= NPIX || data_write[31:1] !== 31'd0) begin
                bad_wr++;
            end else begin
                px = int'(off) % W;
                py = int'(off) / W;
                if (px == 0 || px == W - 1 || py == 0 || py == H - 1) begin
                    bad_wr++;
                end else begin
                    wr_cnt[off]++;
                    wr_val[off] = data_write[0];
                    if (data_write[0] === 1'b1) ones_wr++;
                    last_y = py;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic bit pix(input int x, input int y);
        return src_img[y * W + x];
    endfunction

    function automatic bit keep(input int x, input int y);
        int n = 0;
        for (int dy = -1; dy <= 1; dy++)
            for (int dx = -1; dx <= 1; dx++)
                if (dx != 0 || dy != 0) n += int'(pix(x + dx, y + dy));
        return pix(x, y) && (n >= MIN);
    endfunction

    task automatic clear_log();
        for (int i = 0; i < NPIX; i++) begin
            wr_cnt[i] = 0;
            wr_val[i] = 1'b0;
        end
        n_writes = 0; ones_wr = 0; bad_wr = 0; last_y = 0;
    endtask

    task automatic fill(input int mode);
        for (int i = 0; i < NPIX; i++) begin
            case (mode)
                0:       src_img[i] = 1'b0;
                1:       src_img[i] = 1'b1;
                default: src_img[i] = ($urandom_range(0, 2) == 0);
            endcase
        end
    endtask

    task automatic verify_image(input string tag);
        int bad_cov = 0;
        int bad_val = 0;
        exp_cnt = 0;
        for (int y = 1; y <= H - 2; y++) begin
            for (int x = 1; x <= W - 2; x++) begin
                exp_cnt += int'(keep(x, y));
                if (wr_cnt[y * W + x] != 1) bad_cov++;
                if (wr_val[y * W + x] != keep(x, y)) bad_val++;
            end
        end
        check({tag, "_count"}, count, exp_cnt);
        check({tag, "_coverage"}, bad_cov, 0);
        check({tag, "_values"}, bad_val, 0);
        check({tag, "_stray_writes"}, bad_wr, 0);
        check({tag, "_total_writes"}, n_writes, NINT);
        check({tag, "_ones_written"}, ones_wr, exp_cnt);
    endtask

    task automatic run_pass(input string tag);
        int  cyc = 0;
        bit  got = 1'b0;
        clear_log();
        @(negedge clk);
        enable  = 1'b1;
        reset_n = 1'b1;
        while (!got && cyc < 2 * PASS) begin
            @(posedge clk);
            cyc++;
            #1;
            got = (done === 1'b1);
        end
        check({tag, "_cycles"}, cyc, PASS);
        verify_image(tag);
        repeat (3) @(posedge clk);
        #1;
        check({tag, "_done_held"}, done, 1'b1);
        check({tag, "_no_extra_writes"}, n_writes, NINT);
        @(negedge clk);
        enable = 1'b0;
        @(posedge clk);
        #1;
        check({tag, "_done_clear"}, done, 1'b0);
        check({tag, "_count_held"}, count, exp_cnt);
    endtask

    // Starts a pass, then interrupts it once row 4 is being written.
    task automatic interrupt_pass(input string tag, input bit use_reset);
        int cyc = 0;
        int nw;
        clear_log();
        @(negedge clk);
        enable = 1'b1;
        while (last_y < 4 && cyc < 2 * PASS) begin
            @(posedge clk);
            cyc++;
        end
        check({tag, "_reached_row"}, (last_y >= 4), 1'b1);
        @(negedge clk);
        if (use_reset) reset_n = 1'b0;
        else           enable  = 1'b0;
        #1;
        nw = n_writes;
        repeat (60) @(posedge clk);
        #1;
        check({tag, "_no_writes_after"}, n_writes, nw);
        check({tag, "_done_low"}, done, 1'b0);
        check({tag, "_wren_released"}, (wren === 1'b1), 1'b0);
        if (use_reset) check({tag, "_count_cleared"}, count, 0);
        else           check({tag, "_count_kept"}, count, ones_wr);
    endtask

    initial begin
        clear_log();
        fill(0);
        repeat (3) @(posedge clk);
        #1;
        check("reset_done", done, 1'b0);
        check("reset_count", count, 0);
        check("reset_wren", (wren === 1'b1), 1'b0);

        fill(0);
        run_pass("zeros");

        fill(0);
        src_img[4 * W + 5] = 1'b1;
        run_pass("single");

        src_img[4 * W + 6] = 1'b1;
        run_pass("pair");

        fill(1);
        run_pass("ones");

        fill(2);
        run_pass("random");

        fill(2);
        interrupt_pass("abort", 1'b0);
        run_pass("after_abort");

        fill(2);
        interrupt_pass("reset", 1'b1);
        run_pass("after_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
